// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and control-field encodings shared by the control unit
package mc_pkg;

   localparam int OPW_DEF = 4;
   localparam int FW_DEF  = 3;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MEMADR   = 4'd3;
   localparam logic [3:0] S_MEMREAD  = 4'd4;
   localparam logic [3:0] S_MEMWB    = 4'd5;
   localparam logic [3:0] S_MEMWRITE = 4'd6;
   localparam logic [3:0] S_EXEC_R   = 4'd7;
   localparam logic [3:0] S_EXEC_I   = 4'd8;
   localparam logic [3:0] S_ALUWB    = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_HALT     = 4'd12;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LD    = 4'h2;
   localparam logic [3:0] OP_ST    = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [1:0] SRCB_RD2 = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       halted;
   } ctrl_t;

   function automatic logic op_defined(input logic [3:0] op);
      return (op <= OP_JMP) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - instruction fields in, datapath controls out
interface mc_control_unit_if #(
   parameter int OPW = 4,
   parameter int FW  = 3
);
   logic [OPW-1:0] op;
   logic [FW-1:0]  funct;
   logic           zero;
   logic           pc_en;
   logic           ir_write;
   logic           mem_write;
   logic           reg_write;
   logic           adr_src;
   logic           alu_src_a;
   logic [1:0]     alu_src_b;
   logic [FW-1:0]  alu_ctrl;
   logic [1:0]     result_src;
   logic           halted;
   logic           illegal;

   modport master (
      input  op, funct, zero,
      output pc_en, ir_write, mem_write, reg_write, adr_src, alu_src_a,
             alu_src_b, alu_ctrl, result_src, halted, illegal
   );

   modport slave (
      output op, funct, zero,
      input  pc_en, ir_write, mem_write, reg_write, adr_src, alu_src_a,
             alu_src_b, alu_ctrl, result_src, halted, illegal
   );
endinterface

// File: rtl/mc_control_decode.sv
// rtl/mc_control_decode.sv - Moore control vector decoded from the registered state
module mc_control_decode
   import mc_pkg::*;
#(
   parameter int FW = 3
) (
   input  logic [3:0]    i_state,
   input  logic [FW-1:0] i_funct,
   output ctrl_t         o_ctrl,
   output logic [FW-1:0] o_alu_ctrl
);

   always_comb begin
      o_ctrl     = '0;
      o_alu_ctrl = FW'(ALU_ADD);
      case (i_state)
         S_FETCH: begin
            o_ctrl.ir_write   = 1'b1;
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.alu_src_b  = SRCB_ONE;
            o_ctrl.result_src = RES_ALU;
         end
         S_DECODE:   o_ctrl.alu_src_b = SRCB_IMM;
         S_MEMADR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD:  o_ctrl.adr_src = 1'b1;
         S_MEMWB: begin
            o_ctrl.result_src = RES_MEM;
            o_ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            o_ctrl.adr_src   = 1'b1;
            o_ctrl.mem_write = 1'b1;
         end
         S_EXEC_R: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_RD2;
            o_alu_ctrl       = i_funct;
         end
         S_EXEC_I: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_ALUWB: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_RD2;
            o_ctrl.branch    = 1'b1;
            o_alu_ctrl       = FW'(ALU_SUB);
         end
         S_JUMP: begin
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.result_src = RES_IMM;
         end
         S_HALT:     o_ctrl.halted = 1'b1;
         default:    o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle instruction sequencer for the 8-bit datapath
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int OPW = OPW_DEF,
   parameter int FW  = FW_DEF
) (
   input  logic              clock,
   input  logic              rst,
   mc_control_unit_if.master bus
);

   logic [3:0]    r_state;
   logic [3:0]    w_next;
   logic          r_illegal;
   ctrl_t         w_ctrl;
   logic [FW-1:0] w_alu_ctrl;
   logic [3:0]    w_op;

   assign w_op = 4'(bus.op);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:     w_next = S_FETCH;
         S_FETCH:    w_next = S_DECODE;
         S_DECODE: begin
            case (w_op)
               OP_RTYPE: w_next = S_EXEC_R;
               OP_ADDI:  w_next = S_EXEC_I;
               OP_LD:    w_next = S_MEMADR;
               OP_ST:    w_next = S_MEMADR;
               OP_BEQ:   w_next = S_BRANCH;
               OP_JMP:   w_next = S_JUMP;
               OP_HALT:  w_next = S_HALT;
               default:  w_next = S_FETCH;
            endcase
         end
         // IR is stable after fetch, so re-reading op here is safe
         S_MEMADR:   w_next = (w_op == OP_LD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = S_FETCH;
         S_EXEC_R:   w_next = S_ALUWB;
         S_EXEC_I:   w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JUMP:     w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE && !op_defined(w_op))
            r_illegal <= 1'b1;
      end
   end

   mc_control_decode #(.FW(FW)) u_decode (
      .i_state    (r_state),
      .i_funct    (bus.funct),
      .o_ctrl     (w_ctrl),
      .o_alu_ctrl (w_alu_ctrl)
   );

   assign bus.pc_en      = w_ctrl.pc_write | (w_ctrl.branch & bus.zero);
   assign bus.ir_write   = w_ctrl.ir_write;
   assign bus.mem_write  = w_ctrl.mem_write;
   assign bus.reg_write  = w_ctrl.reg_write;
   assign bus.adr_src    = w_ctrl.adr_src;
   assign bus.alu_src_a  = w_ctrl.alu_src_a;
   assign bus.alu_src_b  = w_ctrl.alu_src_b;
   assign bus.alu_ctrl   = w_alu_ctrl;
   assign bus.result_src = w_ctrl.result_src;
   assign bus.halted     = w_ctrl.halted;
   assign bus.illegal    = r_illegal;

endmodule
